// File: rtl/alif_cfg_sequencer_pkg.sv
// Shared types and default constants for the ALIF neuron configuration sequencer.
// Holds the FSM state encoding and the default frame geometry and timeout.
package alif_cfg_pkg;

    localparam int unsigned NUM_PARAMS  = 4;
    localparam int unsigned PARAM_W     = 8;
    localparam int unsigned TIMEOUT_CYC = 16;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SHIFT    = 3'd1,
        ST_WAIT_RDY = 3'd2,
        ST_DONE     = 3'd3,
        ST_ERR      = 3'd4
    } state_e;

endpackage

// File: rtl/alif_cfg_sequencer_if.sv
// Host-side configuration frame handshake for the ALIF configuration sequencer.
//   cfg_valid : host offers a frame
//   cfg_ready : sequencer can accept a frame
//   cfg_data  : frame, parameter 0 in the most-significant byte
// master = host, slave = sequencer.
interface alif_cfg_sequencer_if #(
    parameter int unsigned FRAME_W = alif_cfg_pkg::NUM_PARAMS * alif_cfg_pkg::PARAM_W
);
    logic               cfg_valid;
    logic               cfg_ready;
    logic [FRAME_W-1:0] cfg_data;

    modport master (
        output cfg_valid,
        output cfg_data,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_data,
        output cfg_ready
    );
endinterface

// File: rtl/alif_cfg_sequencer_piso.sv
// Parallel-in serial-out frame register; shifts toward the MSB so the frame
// leaves MSB first.
//   clk, rst_n : clock, synchronous active-low reset (clears register)
//   i_load     : capture i_data (has priority over i_shift_en)
//   i_shift_en : shift left by one, zero fill
//   i_data     : parallel frame
//   o_q_msb    : current MSB, the bit presented on the serial line
module alif_cfg_piso #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic         i_shift_en,
    input  logic [W-1:0] i_data,
    output logic         o_q_msb
);

    logic [W-1:0] r_q;

    // Frame storage: load wins over shift.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_data;
        end else if (i_shift_en) begin
            r_q <= {r_q[W-2:0], 1'b0};
        end
    end

    assign o_q_msb = r_q[W-1];

endmodule

// File: rtl/alif_cfg_sequencer.sv
// Loads one configuration frame into an ALIF neuron over its serial parameter
// port, then waits (bounded) for the neuron to report its parameters loaded.
//   clk, rst_n      : clock, synchronous active-low reset
//   cfg_if (slave)  : host frame handshake (cfg_valid/cfg_ready/cfg_data)
//   i_en_req        : host request to enable neuron input integration
//   o_load_mode     : neuron load_mode, high for exactly FRAME_W cycles
//   o_serial_data   : neuron serial_data, frame MSB first
//   i_params_ready  : neuron parameter-loaded flag
//   o_input_enable  : neuron input_enable, follows i_en_req only when idle
//   o_busy          : frame in progress
//   o_done          : one-cycle pulse on successful load
//   o_err           : sticky timeout flag, cleared by the next accepted frame
module alif_cfg_sequencer #(
    parameter int unsigned NUM_PARAMS  = alif_cfg_pkg::NUM_PARAMS,
    parameter int unsigned PARAM_W     = alif_cfg_pkg::PARAM_W,
    parameter int unsigned TIMEOUT_CYC = alif_cfg_pkg::TIMEOUT_CYC
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alif_cfg_sequencer_if.slave  cfg_if,
    input  logic                 i_en_req,
    output logic                 o_load_mode,
    output logic                 o_serial_data,
    input  logic                 i_params_ready,
    output logic                 o_input_enable,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_err
);

    import alif_cfg_pkg::*;

    localparam int unsigned FRAME_W    = NUM_PARAMS * PARAM_W;
    localparam int unsigned BIT_CNT_W  = $clog2(FRAME_W + 1);
    localparam int unsigned WAIT_CNT_W = $clog2(TIMEOUT_CYC + 1);

    state_e                r_state;
    state_e                w_state_nxt;
    logic                  w_load;
    logic                  w_shift_en;
    logic                  w_q_msb;
    logic [BIT_CNT_W-1:0]  r_bit_cnt;
    logic [WAIT_CNT_W-1:0] r_wait_cnt;
    logic                  r_err;
    logic                  w_idle;

    // Frame shift register.
    alif_cfg_piso #(
        .W (FRAME_W)
    ) u_piso (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_shift_en (w_shift_en),
        .i_data     (cfg_if.cfg_data),
        .o_q_msb    (w_q_msb)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_shift_en  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // cfg_ready is high throughout IDLE out of reset, so valid alone completes the handshake.
                if (cfg_if.cfg_valid) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                w_shift_en = 1'b1;
                if (r_bit_cnt == BIT_CNT_W'(FRAME_W - 1)) begin
                    w_state_nxt = ST_WAIT_RDY;
                end
            end
            ST_WAIT_RDY: begin
                // Ready on the timeout edge still counts as success.
                if (i_params_ready) begin
                    w_state_nxt = ST_DONE;
                end else if (r_wait_cnt == WAIT_CNT_W'(TIMEOUT_CYC - 1)) begin
                    w_state_nxt = ST_ERR;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            ST_ERR:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Bit and wait counters plus the sticky error flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bit_cnt  <= '0;
            r_wait_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_load) begin
                r_bit_cnt <= '0;
            end else if (r_state == ST_SHIFT) begin
                r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
            end

            if (r_state == ST_WAIT_RDY) begin
                r_wait_cnt <= r_wait_cnt + WAIT_CNT_W'(1);
            end else begin
                r_wait_cnt <= '0;
            end

            if (w_load) begin
                r_err <= 1'b0;
            end else if (w_state_nxt == ST_ERR) begin
                r_err <= 1'b1;
            end
        end
    end

    // Outputs decode registered state; rst_n gates the idle-only outputs so they are low during reset.
    assign w_idle           = (r_state == ST_IDLE);
    assign cfg_if.cfg_ready = rst_n & w_idle;
    assign o_input_enable   = rst_n & w_idle & i_en_req;
    assign o_load_mode      = (r_state == ST_SHIFT);
    assign o_serial_data    = (r_state == ST_SHIFT) & w_q_msb;
    assign o_busy           = ~w_idle;
    assign o_done           = (r_state == ST_DONE);
    assign o_err            = r_err;

endmodule

// File: tb/tb_alif_cfg_sequencer.sv
// Scoreboard bench for alif_cfg_sequencer: stimulus pushes expected serial
// bits, load_mode run lengths and frame outcomes; a negedge monitor pops and
// compares them as the DUT produces them.
`timescale 1ns/1ps
module tb_alif_cfg_sequencer;

    localparam int unsigned FRAME_W = 32;
    localparam int OUT_DONE  = 1;
    localparam int OUT_ERR   = 2;
    localparam int SEL_DONE  = 0;
    localparam int SEL_ERR   = 1;
    localparam int SEL_WAIT  = 2;
    localparam int SEL_READY = 3;

    // Hand-written bit pattern of frame 32'hA53C_0F81, first bit transmitted on the left.
    localparam logic [31:0] EXP_A53C = 32'b1010_0101_0011_1100_0000_1111_1000_0001;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en_req = 1'b0;
    logic params_ready = 1'b0;
    logic load_mode, serial_data, input_enable, busy, done, err;

    alif_cfg_sequencer_if #(.FRAME_W(FRAME_W)) cfg_if ();

    alif_cfg_sequencer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_if         (cfg_if),
        .i_en_req       (en_req),
        .o_load_mode    (load_mode),
        .o_serial_data  (serial_data),
        .i_params_ready (params_ready),
        .o_input_enable (input_enable),
        .o_busy         (busy),
        .o_done         (done),
        .o_err          (err)
    );

    always #5 clk = ~clk;

    int   n_cmp  = 0;
    int   n_fail = 0;
    logic exp_bits[$];
    int   exp_runs[$];
    int   exp_outs[$];
    bit   mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_frame(input logic [31:0] d, input int nbits, input int outcome);
        for (int k = 0; k < nbits; k++) exp_bits.push_back(d[5'(31 - k)]);
        exp_runs.push_back(nbits);
        if (outcome != 0) exp_outs.push_back(outcome);
    endtask

    // Bounded wait on negedges for a DUT condition; an expired bound is a failure.
    task automatic wait_for(input int sel, input int budget, input string name, output int ncyc);
        bit hit;
        hit  = 1'b0;
        ncyc = 0;
        while (!hit && ncyc < budget) begin
            @(negedge clk);
            ncyc++;
            case (sel)
                SEL_DONE:  hit = (done === 1'b1);
                SEL_ERR:   hit = (err === 1'b1);
                SEL_WAIT:  hit = (busy === 1'b1) && (load_mode === 1'b0) && (done === 1'b0) && (err === 1'b0);
                SEL_READY: hit = (cfg_if.cfg_ready === 1'b1);
                default:   hit = 1'b1;
            endcase
        end
        if (!hit) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: condition not seen within %0d cycles", name, budget);
        end
    endtask

    // Offers a frame at a negedge where cfg_ready is high; returns #1 after the handshake edge.
    task automatic send_frame(input logic [31:0] d, input logic [31:0] exp_d, input int nbits, input int outcome);
        int n;
        wait_for(SEL_READY, 50, "ready_wait", n);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_data  = d;
        expect_frame(exp_d, nbits, outcome);
        @(posedge clk);
        #1;
        cfg_if.cfg_valid = 1'b0;
    endtask

    // Monitor: serial bits, load_mode run lengths, done width and frame outcomes.
    bit prev_load = 1'b0;
    bit prev_done = 1'b0;
    bit prev_err  = 1'b0;
    int run_len   = 0;
    int done_len  = 0;
    always @(negedge clk) begin
        if (mon_en) begin
            if (load_mode === 1'b1) begin
                if (exp_bits.size() == 0) chk("bits_pending", 32'(exp_bits.size()), 1);
                else chk("serial_bit", serial_data, exp_bits.pop_front());
                run_len++;
            end else begin
                chk("serial_idle", serial_data, 0);
                if (prev_load) begin
                    if (exp_runs.size() == 0) chk("runs_pending", 32'(exp_runs.size()), 1);
                    else chk("load_mode_cycles", run_len, exp_runs.pop_front());
                    run_len = 0;
                end
            end

            if (done === 1'b1) begin
                done_len++;
                if (!prev_done) begin
                    if (exp_outs.size() == 0) chk("outs_pending_done", 32'(exp_outs.size()), 1);
                    else chk("outcome_done", OUT_DONE, exp_outs.pop_front());
                end
            end else if (prev_done) begin
                chk("done_width", done_len, 1);
                done_len = 0;
            end

            if (err === 1'b1 && !prev_err) begin
                if (exp_outs.size() == 0) chk("outs_pending_err", 32'(exp_outs.size()), 1);
                else chk("outcome_err", OUT_ERR, exp_outs.pop_front());
            end

            prev_load = (load_mode === 1'b1);
            prev_done = (done === 1'b1);
            prev_err  = (err === 1'b1);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_data  = '0;

        // Reset with en_req high: idle-only outputs must stay low.
        rst_n  = 1'b0;
        en_req = 1'b1;
        repeat (2) @(negedge clk);
        mon_en = 1'b1;
        chk("rst_cfg_ready", cfg_if.cfg_ready, 0);
        chk("rst_input_enable", input_enable, 0);
        chk("rst_load_mode", load_mode, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_cfg_ready", cfg_if.cfg_ready, 1);
        chk("post_rst_input_enable", input_enable, 1);

        // Frame A53C0F81, params_ready three cycles after SHIFT ends.
        send_frame(32'hA53C_0F81, EXP_A53C, 32, OUT_DONE);
        @(negedge clk);
        chk("t2_input_enable_busy", input_enable, 0);
        chk("t2_busy", busy, 1);
        chk("t2_cfg_ready_busy", cfg_if.cfg_ready, 0);
        wait_for(SEL_WAIT, 40, "t2_shift_end", n);
        chk("t2_input_enable_wait", input_enable, 0);
        repeat (3) @(posedge clk);
        #1 params_ready = 1'b1;
        wait_for(SEL_DONE, 10, "t2_done", n);
        params_ready = 1'b0;
        chk("t2_err", err, 0);
        chk("t2_input_enable_done", input_enable, 0);
        @(negedge clk);
        chk("t2_done_cleared", done, 0);
        chk("t2_cfg_ready_back", cfg_if.cfg_ready, 1);
        chk("t2_input_enable_idle", input_enable, 1);

        // Timeout: params_ready held low.
        send_frame(32'h1234_5678, 32'h1234_5678, 32, OUT_ERR);
        wait_for(SEL_WAIT, 40, "t3_shift_end", n);
        wait_for(SEL_ERR, 30, "t3_err", n);
        chk("t3_wait_cycles", n, 16);
        chk("t3_no_done", done, 0);
        chk("t3_busy_err", busy, 1);
        @(negedge clk);
        chk("t3_err_sticky", err, 1);
        chk("t3_idle", busy, 0);
        chk("t3_cfg_ready", cfg_if.cfg_ready, 1);
        repeat (3) @(negedge clk);
        chk("t3_err_still", err, 1);

        // params_ready in IDLE is ignored.
        params_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("t4_idle_rdy_busy", busy, 0);
        chk("t4_idle_rdy_done", done, 0);
        params_ready = 1'b0;

        // New frame clears err; params_ready during SHIFT ignored; ready on the timeout edge wins.
        send_frame(32'h0000_0001, 32'h0000_0001, 32, OUT_DONE);
        @(negedge clk);
        chk("t4_err_cleared", err, 0);
        repeat (4) @(negedge clk);
        params_ready = 1'b1;
        repeat (6) @(negedge clk);
        params_ready = 1'b0;
        chk("t4_shift_continues", load_mode, 1);
        wait_for(SEL_WAIT, 40, "t4_shift_end", n);
        repeat (15) @(posedge clk);
        #1 params_ready = 1'b1;
        wait_for(SEL_DONE, 5, "t4_done", n);
        params_ready = 1'b0;
        chk("t4_done_latency", n, 2);
        chk("t4_err", err, 0);

        // cfg_valid held with new data during SHIFT; second frame only from IDLE.
        wait_for(SEL_READY, 50, "t5_ready", n);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_data  = 32'hC300_FF5A;
        expect_frame(32'hC300_FF5A, 32, OUT_DONE);
        params_ready = 1'b1;
        @(posedge clk); #1;
        repeat (5) @(posedge clk);
        #1 cfg_if.cfg_data = 32'h0F0F_0F0F;
        expect_frame(32'h0F0F_0F0F, 32, OUT_DONE);
        wait_for(SEL_DONE, 60, "t5_done1", n);
        @(posedge clk); #1;
        chk("t5_idle_ready", cfg_if.cfg_ready, 1);
        @(posedge clk); #1;
        cfg_if.cfg_valid = 1'b0;
        chk("t5_second_accept", busy, 1);
        chk("t5_ready_low", cfg_if.cfg_ready, 0);
        wait_for(SEL_DONE, 60, "t5_done2", n);
        params_ready = 1'b0;
        @(negedge clk);
        chk("t5_idle", busy, 0);

        // Reset during SHIFT bit 10 aborts the frame.
        send_frame(32'hA53C_0F81, EXP_A53C, 11, 0);
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t6_load_mode_drop", load_mode, 0);
        chk("t6_cfg_ready_rst", cfg_if.cfg_ready, 0);
        chk("t6_input_enable_rst", input_enable, 0);
        chk("t6_busy", busy, 0);
        chk("t6_no_done", done, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_cfg_ready_after", cfg_if.cfg_ready, 1);
        chk("t6_input_enable_after", input_enable, 1);

        repeat (5) @(negedge clk);
        chk("bits_drained", 32'(exp_bits.size()), 0);
        chk("runs_drained", 32'(exp_runs.size()), 0);
        chk("outs_drained", 32'(exp_outs.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/alif_cfg_sequencer.md
ALIF_CFG_SEQUENCER -- requirements
Module: alif_cfg_sequencer

Interface
REQ-001: Parameter NUM_PARAMS, default 4, number of 8-bit neuron parameters per configuration frame.
REQ-002: Parameter PARAM_W, default 8, width of each parameter; FRAME_W = NUM_PARAMS*PARAM_W (default 32).
REQ-003: Parameter TIMEOUT_CYC, default 16, maximum cycles to wait for params_ready after the last serial bit.
REQ-004: clk  input  1  clock; reset rst_n, synchronous, active-low; clock clk.
REQ-005: rst_n  input  1  synchronous active-low reset.
REQ-006: cfg_valid  input  1  configuration frame offered by host.
REQ-007: cfg_ready  output  1  sequencer can accept a frame.
REQ-008: cfg_data  input  FRAME_W  frame; parameter 0 in the most-significant byte.
REQ-009: en_req  input  1  host request to enable neuron input integration.
REQ-010: load_mode  output  1  drives neuron load_mode.
REQ-011: serial_data  output  1  drives neuron serial_data.
REQ-012: params_ready  input  1  neuron parameter-loaded flag.
REQ-013: input_enable  output  1  drives neuron input_enable.
REQ-014: busy  output  1  frame in progress.
REQ-015: done  output  1  one-cycle pulse on successful load.
REQ-016: err  output  1  sticky timeout flag.

Function
REQ-017: FSM states IDLE, SHIFT, WAIT_RDY, DONE, ERR.
REQ-018: cfg_ready SHALL be 1 only in IDLE; handshake completes on a rising edge with cfg_valid=1 and cfg_ready=1.
REQ-019: On handshake, cfg_data SHALL be captured into a FRAME_W shift register, bit counter cleared, err cleared, and state SHALL go to SHIFT.
REQ-020: In SHIFT, load_mode=1 and serial_data = frame bit FRAME_W-1-k on the k-th SHIFT cycle (MSB first), exactly FRAME_W cycles, then WAIT_RDY.
REQ-021: Outside SHIFT, load_mode=0 and serial_data=0.
REQ-022: In WAIT_RDY, a wait counter SHALL increment each cycle; params_ready=1 sampled at an edge SHALL move to DONE; counter reaching TIMEOUT_CYC with params_ready=0 SHALL move to ERR.
REQ-023: params_ready=1 on the same edge the counter reaches TIMEOUT_CYC SHALL take priority (DONE).
REQ-024: params_ready during SHIFT or IDLE SHALL be ignored.
REQ-025: DONE SHALL last one cycle with done=1, then IDLE; ERR SHALL last one cycle, set err=1, then IDLE.
REQ-026: err SHALL remain 1 until the next accepted frame or reset.
REQ-027: busy SHALL be 1 in SHIFT, WAIT_RDY, DONE, ERR.
REQ-028: input_enable SHALL equal en_req in IDLE and 0 in every other state.
REQ-029: cfg_valid changes while busy SHALL have no effect; cfg_data is not re-sampled.
REQ-030: All outputs SHALL be registered or decoded from registered state only; no combinational path from inputs to outputs except en_req -> input_enable.

Reset
REQ-031: On rst_n=0 at a clock edge: state IDLE, shift register and counters 0, err 0, done 0, load_mode 0, serial_data 0, busy 0.
REQ-032: During reset, cfg_ready=0 and input_enable=0.
REQ-033: Reset mid-SHIFT or mid-WAIT_RDY SHALL abort the frame; load_mode SHALL be 0 from the first reset edge; no done pulse.

Structure
REQ-034: Package alif_cfg_pkg SHALL hold the state enum and default constants (NUM_PARAMS, PARAM_W, TIMEOUT_CYC).
REQ-035: The parallel-in serial-out register SHALL be sub-module alif_cfg_piso (load, shift_en, q_msb).
REQ-036: Counter widths SHALL be $clog2(FRAME_W+1) and $clog2(TIMEOUT_CYC+1).

Verification
REQ-037: Reset, then cfg_data=32'hA5_3C_0F_81 handshake -> load_mode high 32 cycles, serial bits 1010_0101_0011_1100_0000_1111_1000_0001.
REQ-038: params_ready asserted 3 cycles after SHIFT ends -> done pulse exactly one cycle, err=0, cfg_ready back next cycle.
REQ-039: params_ready held 0 -> err=1 after 16 WAIT_RDY cycles, no done; next accepted frame clears err.
REQ-040: en_req=1 throughout a frame -> input_enable 0 from handshake until return to IDLE, then 1.
REQ-041: rst_n=0 at SHIFT bit 10 -> load_mode 0 next edge, no done, cfg_ready 1 after reset release.
REQ-042: cfg_valid held high with new data during SHIFT -> transmitted bits unchanged; second frame accepted only in IDLE.
